// File: rtl/subseq_sched_pkg.sv
// Shared types and defaults for the round-robin subseq_sum scheduler.
// Kept in one place so the top and the arbiter agree on widths.
package subseq_sched_pkg;

  typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, DONE} state_t;

  localparam int N_REQ_DEF     = 2;
  localparam int FRAME_LEN_DEF = 8;
  localparam int DW_DEF        = 8;
  localparam int SW_DEF        = 12;
  localparam int TIMEOUT_DEF   = 200;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subseq_sum_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request strictly
// after last_grant wins, so the previous winner has the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  logic [IW-1:0]    rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  // rot_req[k] is the request k+1 positions after last_grant (modulo N_REQ).
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IW:0] raw;
    assign raw         = {1'b0, last_grant} + (IW+1)'(gi + 1);
    assign rot_idx[gi] = (raw >= (IW+1)'(N_REQ)) ? IW'(raw - (IW+1)'(N_REQ)) : IW'(raw);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && rot_req[k]) begin
        any       = 1'b1;
        grant_idx = rot_idx[k];
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/subseq_sum_sched.sv
// Shares one subseq_sum engine among N_REQ frame sources: grant, clear the
// engine, stream one frame, then wait for the result or a timeout.
module subseq_sum_sched
  import subseq_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW        = DW_DEF,
  parameter int SW        = SW_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     eng_rst,
  output logic                     eng_valid_in,
  output logic [DW-1:0]            eng_data_in,
  input  logic                     eng_valid_out,
  input  logic [SW-1:0]            eng_max_sum,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [SW-1:0]            res_sum,
  output logic                     res_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = cnt_width(FRAME_LEN);
  localparam int TW = cnt_width(TIMEOUT);

  state_t           state_reg;
  logic [IW-1:0]    grant_id_reg;
  logic [IW-1:0]    last_grant_reg;
  logic [N_REQ-1:0] grant_oh_reg;
  logic [BW-1:0]    beat_cnt_reg;
  logic [TW-1:0]    to_cnt_reg;

  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             beat;
  logic [DW-1:0]    sample;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant_reg),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Decoded from state so an async reset drops the acknowledge immediately.
  assign req_ready = (state_reg == FEED) ? grant_oh_reg : '0;
  assign beat      = |(req_valid & req_ready);
  assign sample    = req_data[int'(grant_id_reg)*DW +: DW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      grant_oh_reg   <= '0;
      last_grant_reg <= IW'(N_REQ - 1);
      beat_cnt_reg   <= '0;
      to_cnt_reg     <= '0;
      eng_rst        <= 1'b1;
      eng_valid_in   <= 1'b0;
      eng_data_in    <= '0;
      res_valid      <= 1'b0;
      res_id         <= '0;
      res_sum        <= '0;
      res_err        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          eng_rst      <= 1'b0;
          eng_valid_in <= 1'b0;
          if (arb_any) begin
            grant_id_reg <= arb_idx;
            grant_oh_reg <= arb_oh;
            eng_rst      <= 1'b1;  // high during the CLR cycle only
            state_reg    <= CLR;
          end
        end
        CLR: begin
          eng_rst      <= 1'b0;
          eng_valid_in <= 1'b0;
          beat_cnt_reg <= '0;
          state_reg    <= FEED;
        end
        FEED: begin
          eng_valid_in <= beat;
          if (beat) begin
            eng_data_in <= sample;
            if (beat_cnt_reg == BW'(FRAME_LEN - 1)) begin
              to_cnt_reg <= '0;
              state_reg  <= WAIT;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        WAIT: begin
          eng_valid_in <= 1'b0;
          to_cnt_reg   <= to_cnt_reg + 1'b1;
          if (eng_valid_out) begin
            res_sum   <= eng_max_sum;
            res_err   <= 1'b0;
            res_id    <= grant_id_reg;
            res_valid <= 1'b1;
            state_reg <= DONE;
          end else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
            res_sum   <= '0;
            res_err   <= 1'b1;
            res_id    <= grant_id_reg;
            res_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid      <= 1'b0;
            last_grant_reg <= grant_id_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subseq_sum_sched.sv
// Bench for subseq_sum_sched with a behavioural max-subsequence engine and a
// brute-force reference for the expected sums.
module tb_subseq_sum_sched;

  localparam int N_REQ     = 2;
  localparam int FRAME_LEN = 8;
  localparam int DW        = 8;
  localparam int SW        = 12;
  localparam int TIMEOUT   = 200;
  localparam int LIMIT     = 2000;
  localparam int GAP_LEN   = 2;

  typedef logic [FRAME_LEN-1:0][DW-1:0] frame_t;
  typedef struct packed {
    logic [31:0] id;
    frame_t      smp;
    logic [7:0]  gap;
    logic [31:0] exp_sum;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                eng_rst;
  logic                eng_valid_in;
  logic [DW-1:0]       eng_data_in;
  logic                eng_valid_out = 1'b0;
  logic [SW-1:0]       eng_max_sum = '0;
  logic                res_valid;
  logic                res_ready;
  logic [0:0]          res_id;
  logic [SW-1:0]       res_sum;
  logic                res_err;

  logic                rv [N_REQ];
  logic [DW-1:0]       rd [N_REQ];
  logic                eng_en;
  logic                abort;

  int n_cmp = 0;
  int n_fail = 0;
  int mon_beats = 0, mon_rst_cyc = 0, proto_viol = 0;
  int base_beats = 0, base_rst = 0, base_q = 0;
  logic [DW-1:0] mon_data [$];
  vec_t vecs [5];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_valid[gi]          = rv[gi];
    assign req_data[gi*DW +: DW]  = rd[gi];
  end

  subseq_sum_sched #(
    .N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .DW(DW), .SW(SW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_rst(eng_rst), .eng_valid_in(eng_valid_in), .eng_data_in(eng_data_in),
    .eng_valid_out(eng_valid_out), .eng_max_sum(eng_max_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_sum(res_sum), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Engine: running best suffix (empty allowed), result one cycle after the last sample.
  int e_cur, e_best, e_cnt;
  always @(posedge clk) begin : eng
    int nc, nb;
    eng_valid_out <= 1'b0;
    if (eng_rst) begin
      e_cur <= 0; e_best <= 0; e_cnt <= 0;
    end else if (eng_valid_in) begin
      nc = e_cur + int'($signed(eng_data_in));
      if (nc < 0) nc = 0;
      nb = (nc > e_best) ? nc : e_best;
      e_cur  <= nc;
      e_best <= nb;
      e_cnt  <= e_cnt + 1;
      if (e_cnt == FRAME_LEN - 1 && eng_en) begin
        eng_valid_out <= 1'b1;
        eng_max_sum   <= SW'(nb);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (eng_rst) mon_rst_cyc <= mon_rst_cyc + 1;
      if (eng_valid_in) begin
        mon_beats <= mon_beats + 1;
        mon_data.push_back(eng_data_in);
      end
      if (!$onehot0(req_ready)) proto_viol <= proto_viol + 1;
    end
  end

  // Reference: largest sum over every contiguous run, the empty run counting as 0.
  function automatic int max_sub(input frame_t s);
    int best, acc;
    best = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      acc = 0;
      for (int j = i; j < FRAME_LEN; j++) begin
        acc += int'($signed(s[j]));
        if (acc > best) best = acc;
      end
    end
    return best;
  endfunction

  function automatic vec_t mk(input int id, input int a [8], input logic [7:0] gap, input int exp_sum);
    vec_t v;
    v.id = id; v.gap = gap; v.exp_sum = exp_sum;
    for (int i = 0; i < FRAME_LEN; i++) v.smp[i] = DW'(a[i]);
    return v;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic mark();
    base_beats = mon_beats;
    base_rst   = mon_rst_cyc;
    base_q     = mon_data.size();
  endtask

  task automatic send_frame(input int id, input frame_t smp, input logic [7:0] gap);
    int n;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (abort) begin rv[id] = 1'b0; return; end
      rv[id] = 1'b1;
      rd[id] = smp[i];
      n = 0;
      while (!req_ready[id] && !abort && n < LIMIT) begin @(negedge clk); n++; end
      if (abort) begin rv[id] = 1'b0; return; end
      check_eq("ready_wait", n < LIMIT, 1);
      if (n >= LIMIT) begin rv[id] = 1'b0; return; end
      @(negedge clk);
      if (gap[i]) begin rv[id] = 1'b0; repeat (GAP_LEN) @(negedge clk); end
    end
    rv[id] = 1'b0;
  endtask

  task automatic get_result(input int exp_id, input frame_t smp, input int exp_sum, input logic exp_err);
    int n, mism;
    n = 0;
    while (!res_valid && n < LIMIT) begin @(negedge clk); n++; end
    check_eq("res_wait", n < LIMIT, 1);
    check_eq("res_id", res_id, exp_id);
    check_eq("res_sum", res_sum, exp_sum);
    check_eq("res_err", res_err, exp_err);
    check_eq("beats", mon_beats - base_beats, FRAME_LEN);
    check_eq("eng_rst_cycles", mon_rst_cyc - base_rst, 1);
    mism = 0;
    for (int i = 0; i < FRAME_LEN; i++)
      if (base_q + i >= mon_data.size() || mon_data[base_q + i] !== smp[i]) mism++;
    check_eq("stream_data", mism, 0);
    $display("frame id=%0d sum=%0d err=%0d (expected id=%0d sum=%0d err=%0d)",
             res_id, res_sum, res_err, exp_id, exp_sum, exp_err);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("res_valid_clr", res_valid, 0);
    mark();
  endtask

  initial begin
    int t [8];
    int n, id;
    frame_t f;

    res_ready = 1'b0; eng_en = 1'b1; abort = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin rv[i] = 1'b0; rd[i] = '0; end

    t = '{-7, 1, -3, 2, -1, 1, 3, -5};       vecs[0] = mk(0, t, 8'h00, 5);
    t = '{3, -2, 4, -1, 2, -8, 6, 1};        vecs[1] = mk(1, t, 8'h14, 7);
    t = '{127, 127, 127, 127, 127, 127, 127, 127}; vecs[2] = mk(0, t, 8'h00, 1016);
    t = '{-128, 100, 27, -1, 1, -50, 20, 30}; vecs[3] = mk(1, t, 8'h01, 127);
    t = '{10, -20, 5, 5, -1, 3, -100, 50};   vecs[4] = mk(0, t, 8'h40, 50);

    #1 rst = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_eng_rst", eng_rst, 1);
    check_eq("rst_eng_valid_in", eng_valid_in, 0);
    check_eq("rst_eng_data_in", eng_data_in, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_id", res_id, 0);
    check_eq("rst_res_sum", res_sum, 0);
    check_eq("rst_res_err", res_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mark();

    // Simultaneous requests straight after reset: requester 0 first.
    fork
      send_frame(0, vecs[4].smp, 8'h00);
      send_frame(1, vecs[2].smp, 8'h00);
      begin
        get_result(0, vecs[4].smp, 50, 1'b0);
        get_result(1, vecs[2].smp, 1016, 1'b0);
      end
    join

    for (int v = 0; v < 5; v++) begin
      fork
        send_frame(int'(vecs[v].id), vecs[v].smp, vecs[v].gap);
        get_result(int'(vecs[v].id), vecs[v].smp, int'(vecs[v].exp_sum), 1'b0);
      join
    end

    // Result held back while requester 1 waits: nothing may move.
    fork
      send_frame(0, vecs[0].smp, 8'h00);
      begin repeat (3) @(negedge clk); send_frame(1, vecs[3].smp, 8'h00); end
      begin
        n = 0;
        while (!res_valid && n < LIMIT) begin @(negedge clk); n++; end
        check_eq("stall_wait", n < LIMIT, 1);
        for (int k = 0; k < 10; k++) begin
          check_eq("stall_hold", {res_valid, res_id, res_err, req_ready, eng_rst, res_sum},
                   {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 12'd5});
          @(negedge clk);
        end
        get_result(0, vecs[0].smp, 5, 1'b0);
        get_result(1, vecs[3].smp, 127, 1'b0);
      end
    join

    // Silent engine: error result exactly TIMEOUT cycles into WAIT.
    eng_en = 1'b0;
    send_frame(0, vecs[0].smp, 8'h00);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("timeout_early", res_valid, 0);
    @(negedge clk);
    check_eq("timeout_exact", res_valid, 1);
    get_result(0, vecs[0].smp, 0, 1'b1);
    eng_en = 1'b1;

    // Reset in the middle of a frame.
    fork
      send_frame(0, vecs[2].smp, 8'h00);
      begin
        n = 0;
        while ((mon_beats - base_beats) < 4 && n < LIMIT) begin @(negedge clk); n++; end
        check_eq("rst_wait", n < LIMIT, 1);
        #2 rst = 1'b0; abort = 1'b1;
        #1;
        check_eq("rst_mid", {eng_rst, eng_valid_in, eng_data_in, req_ready, res_valid, res_err, res_sum},
                 {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 12'h000});
      end
    join
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold", {res_valid, eng_rst, req_ready}, {1'b0, 1'b1, 2'b00});
    end
    rst = 1'b1;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_no_result", res_valid, 0);
    mark();
    fork
      send_frame(0, vecs[0].smp, 8'h00);
      get_result(0, vecs[0].smp, 5, 1'b0);
    join

    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(0, N_REQ - 1));
      for (int i = 0; i < FRAME_LEN; i++) f[i] = DW'($urandom);
      fork
        send_frame(id, f, 8'($urandom_range(0, 127)));
        get_result(id, f, max_sub(f), 1'b0);
      join
    end

    check_eq("req_ready_onehot0", proto_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
